// File: rtl/uart_fifo_ctrl_pkg.sv
// Shared definitions for the buffered UART controller: register map,
// STATUS / IRQ_EN bit positions and the TX drain state encoding.
package uart_fifo_ctrl_pkg;

    localparam logic [7:0] A_TX_DATA   = 8'd0;
    localparam logic [7:0] A_STATUS    = 8'd1;
    localparam logic [7:0] A_RX_DATA   = 8'd2;
    localparam logic [7:0] A_IRQ_EN    = 8'd3;
    localparam logic [7:0] A_TX_LEVEL  = 8'd4;
    localparam logic [7:0] A_RX_LEVEL  = 8'd5;
    localparam logic [7:0] A_TX_CNT_HI = 8'd6;
    localparam logic [7:0] A_TX_CNT_LO = 8'd7;
    localparam logic [7:0] A_RX_CNT_HI = 8'd8;
    localparam logic [7:0] A_RX_CNT_LO = 8'd9;

    localparam int ST_TX_NOT_FULL  = 0;
    localparam int ST_RX_NOT_EMPTY = 1;
    localparam int ST_TX_EMPTY     = 2;
    localparam int ST_RX_FULL      = 3;
    localparam int ST_RX_OVR       = 4;
    localparam int ST_TX_OVF       = 5;
    localparam int ST_TX_IDLE      = 6;

    localparam int IE_RX_NOT_EMPTY = 0;
    localparam int IE_TX_EMPTY     = 1;
    localparam int IE_ERR          = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_LOAD  = 2'd1,
        TX_ACK   = 2'd2,
        TX_DRAIN = 2'd3
    } tx_state_t;

    // Assemble the STATUS register image from its individual conditions.
    function automatic logic [7:0] pack_status(
        input logic tx_not_full, input logic rx_not_empty, input logic tx_empty,
        input logic rx_full, input logic rx_ovr, input logic tx_ovf,
        input logic tx_idle);
        logic [7:0] s;
        s                  = '0;
        s[ST_TX_NOT_FULL]  = tx_not_full;
        s[ST_RX_NOT_EMPTY] = rx_not_empty;
        s[ST_TX_EMPTY]     = tx_empty;
        s[ST_RX_FULL]      = rx_full;
        s[ST_RX_OVR]       = rx_ovr;
        s[ST_TX_OVF]       = tx_ovf;
        s[ST_TX_IDLE]      = tx_idle;
        return s;
    endfunction

endpackage

// File: rtl/uart_fifo_ctrl_if.sv
// Local IO bus seen by the UART controller: level request, one-cycle rdy.
interface uart_fifo_ctrl_if;
    logic [7:0] addr;
    logic       cs;
    logic       req;
    logic       rnw;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rdy;
    logic       irq;

    modport master (output addr, cs, req, rnw, wr_data, input rd_data, rdy, irq);
    modport slave  (input addr, cs, req, rnw, wr_data, output rd_data, rdy, irq);
endinterface

// File: rtl/uart.sv
// Existing 8N1 UART core, 32x oversampling on clk32; tx_ready is high while
// the transmitter is idle, rx_enable pulses once per good received byte.
module uart (
    input  logic       clk32,
    input  logic       reset_,
    input  logic       rx,
    output logic       tx,
    input  logic [7:0] tx_data,
    input  logic       tx_enable,
    output logic       tx_ready,
    output logic [7:0] rxdata,
    output logic       rx_enable
);
    logic       tx_busy;
    logic [9:0] tx_shift;
    logic [4:0] tx_tick;
    logic [3:0] tx_bits;

    always_ff @(posedge clk32 or negedge reset_) begin
        if (!reset_) begin
            tx_busy  <= 1'b0;
            tx_shift <= '1;
            tx_tick  <= '0;
            tx_bits  <= '0;
        end else if (!tx_busy) begin
            if (tx_enable) begin
                tx_busy  <= 1'b1;
                tx_shift <= {1'b1, tx_data, 1'b0};
                tx_tick  <= 5'd31;
                tx_bits  <= 4'd9;
            end
        end else if (tx_tick != 5'd0) begin
            tx_tick <= tx_tick - 5'd1;
        end else begin
            tx_tick <= 5'd31;
            if (tx_bits == 4'd0) begin
                tx_busy <= 1'b0;
            end else begin
                tx_shift <= {1'b1, tx_shift[9:1]};
                tx_bits  <= tx_bits - 4'd1;
            end
        end
    end

    assign tx       = tx_busy ? tx_shift[0] : 1'b1;
    assign tx_ready = ~tx_busy;

    logic       rx_s1, rx_s2, rx_busy;
    logic [4:0] rx_tick;
    logic [3:0] rx_bits;
    logic [7:0] rx_shift;

    // rx_bits: 9 = start bit, 8..1 = data LSB first, 0 = stop bit
    always_ff @(posedge clk32 or negedge reset_) begin
        if (!reset_) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_busy   <= 1'b0;
            rx_tick   <= '0;
            rx_bits   <= '0;
            rx_shift  <= '0;
            rxdata    <= '0;
            rx_enable <= 1'b0;
        end else begin
            rx_s1     <= rx;
            rx_s2     <= rx_s1;
            rx_enable <= 1'b0;
            if (!rx_busy) begin
                if (!rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_tick <= 5'd15;
                    rx_bits <= 4'd9;
                end
            end else if (rx_tick != 5'd0) begin
                rx_tick <= rx_tick - 5'd1;
            end else begin
                rx_tick <= 5'd31;
                rx_bits <= rx_bits - 4'd1;
                if (rx_bits == 4'd9) begin
                    if (rx_s2) rx_busy <= 1'b0;
                end else if (rx_bits == 4'd0) begin
                    rx_busy <= 1'b0;
                    if (rx_s2) begin
                        rx_enable <= 1'b1;
                        rxdata    <= rx_shift;
                    end
                end else begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                end
            end
        end
    end
endmodule

// File: rtl/uart_fifo_ctrl_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only when a pop
// happens in the same cycle, so the occupancy stays unchanged.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push, do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_fifo_ctrl.sv
// Buffered UART controller: TX/RX FIFOs around the uart core, register file,
// sticky error flags, byte counters and a maskable registered interrupt.
//
// TX drain FSM
//   state    | meaning
//   TX_IDLE  | waiting for a queued byte and an idle core; pops head on entry to LOAD
//   TX_LOAD  | tx_enable high for this single cycle, TX_CNT increments
//   TX_ACK   | waiting for the core to drop tx_ready
//   TX_DRAIN | frame on the wire, waiting for tx_ready to return
module uart_fifo_ctrl
    import uart_fifo_ctrl_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic clk,
    input  logic reset_,
    output logic tx,
    input  logic rx,
    uart_fifo_ctrl_if.slave bus
);
    localparam int TX_LW = $clog2(TX_DEPTH) + 1;
    localparam int RX_LW = $clog2(RX_DEPTH) + 1;

    logic             req_q, acc, wr, rd;
    logic             tx_wr, st_wr, tx_ovf_set, rx_ovr_set;
    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]       tx_dout, rx_dout;
    logic [TX_LW-1:0] tx_level;
    logic [RX_LW-1:0] rx_level;
    logic [7:0]       tx_data_q, rxdata;
    logic             tx_enable, tx_ready, rx_enable;
    logic             tx_ovf, rx_ovr, tx_idle;
    logic [2:0]       irq_en, irq_src;
    logic [15:0]      tx_cnt, rx_cnt;
    logic [7:0]       status, rd_mux;
    tx_state_t        state, state_n;

    // One access per rising edge of req, however long the master holds it.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) req_q <= 1'b0;
        else         req_q <= bus.req;
    end

    assign acc = bus.cs & bus.req & ~req_q;
    assign wr  = acc & ~bus.rnw;
    assign rd  = acc & bus.rnw;

    assign tx_wr      = wr & (bus.addr == A_TX_DATA);
    assign st_wr      = wr & (bus.addr == A_STATUS);
    assign tx_push    = tx_wr & (~tx_full | tx_pop);
    assign tx_ovf_set = tx_wr & tx_full & ~tx_pop;
    assign rx_pop     = rd & (bus.addr == A_RX_DATA) & ~rx_empty;
    assign rx_push    = rx_enable & (~rx_full | rx_pop);
    assign rx_ovr_set = rx_enable & rx_full & ~rx_pop;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset_(reset_), .push(tx_push), .pop(tx_pop),
        .din(bus.wr_data), .dout(tx_dout), .full(tx_full), .empty(tx_empty),
        .level(tx_level)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset_(reset_), .push(rx_push), .pop(rx_pop),
        .din(rxdata), .dout(rx_dout), .full(rx_full), .empty(rx_empty),
        .level(rx_level)
    );

    uart u_uart (
        .clk32(clk), .reset_(reset_), .rx(rx), .tx(tx),
        .tx_data(tx_data_q), .tx_enable(tx_enable), .tx_ready(tx_ready),
        .rxdata(rxdata), .rx_enable(rx_enable)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state <= TX_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n   = state;
        tx_pop    = 1'b0;
        tx_enable = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!tx_empty && tx_ready) begin
                    tx_pop  = 1'b1;
                    state_n = TX_LOAD;
                end
            end
            TX_LOAD: begin
                tx_enable = 1'b1;
                state_n   = TX_ACK;
            end
            TX_ACK:   if (!tx_ready) state_n = TX_DRAIN;
            TX_DRAIN: if (tx_ready)  state_n = TX_IDLE;
            default:  state_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)     tx_data_q <= '0;
        else if (tx_pop) tx_data_q <= tx_dout;
    end

    // A flag being set in the same cycle as its software clear stays set.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            tx_ovf <= 1'b0;
            rx_ovr <= 1'b0;
            irq_en <= '0;
            tx_cnt <= '0;
            rx_cnt <= '0;
        end else begin
            tx_ovf <= tx_ovf_set | (tx_ovf & ~(st_wr & bus.wr_data[ST_TX_OVF]));
            rx_ovr <= rx_ovr_set | (rx_ovr & ~(st_wr & bus.wr_data[ST_RX_OVR]));
            if (wr && (bus.addr == A_IRQ_EN)) irq_en <= bus.wr_data[2:0];
            if (state == TX_LOAD) tx_cnt <= tx_cnt + 16'd1;
            if (rx_enable)        rx_cnt <= rx_cnt + 16'd1;
        end
    end

    assign tx_idle = tx_empty & (state == TX_IDLE) & tx_ready;
    assign status  = pack_status(~tx_full, ~rx_empty, tx_empty, rx_full,
                                 rx_ovr, tx_ovf, tx_idle);

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            A_STATUS:    rd_mux = status;
            A_RX_DATA:   rd_mux = rx_empty ? 8'h00 : rx_dout;
            A_IRQ_EN:    rd_mux = {5'b0, irq_en};
            A_TX_LEVEL:  rd_mux = 8'(tx_level);
            A_RX_LEVEL:  rd_mux = 8'(rx_level);
            A_TX_CNT_HI: rd_mux = tx_cnt[15:8];
            A_TX_CNT_LO: rd_mux = tx_cnt[7:0];
            A_RX_CNT_HI: rd_mux = rx_cnt[15:8];
            A_RX_CNT_LO: rd_mux = rx_cnt[7:0];
            default:     rd_mux = '0;
        endcase
    end

    assign irq_src[IE_RX_NOT_EMPTY] = ~rx_empty;
    assign irq_src[IE_TX_EMPTY]     = tx_empty;
    assign irq_src[IE_ERR]          = rx_ovr | tx_ovf;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            bus.rdy     <= 1'b0;
            bus.rd_data <= '0;
            bus.irq     <= 1'b0;
        end else begin
            bus.rdy <= acc;
            if (rd) bus.rd_data <= rd_mux;
            bus.irq <= |(irq_en & irq_src);
        end
    end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench for uart_fifo_ctrl: bus reads and serial TX bytes are
// queued as expectations and checked by independent monitors.
module tb_uart_fifo_ctrl;
    localparam int DEPTH = 16;
    localparam int BIT_CYC = 32;

    logic clk = 1'b0;
    logic reset_ = 1'b0;
    logic rx = 1'b1;
    logic tx;

    uart_fifo_ctrl_if bus ();

    uart_fifo_ctrl #(.TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_(reset_), .tx(tx), .rx(rx), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q [$];
    bit         chk_q [$];
    string      name_q [$];
    logic [7:0] tx_exp_q [$];
    bit         mon_en;
    int         txen_cnt = 0;

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    // Bus response monitor
    always @(negedge clk) begin
        logic [7:0] e;
        bit c;
        string nm;
        if (bus.rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rdy: rdy=1 with no access pending, rd_data %02h", bus.rd_data);
            end else begin
                e  = exp_q.pop_front();
                c  = chk_q.pop_front();
                nm = name_q.pop_front();
                if (c) cmp(nm, bus.rd_data, e);
            end
        end
    end

    always @(negedge clk) if (reset_ && dut.tx_enable === 1'b1) txen_cnt++;

    // Serial TX decoder, samples mid-bit
    int         tm_cnt, tm_idx;
    bit         tm_busy = 0;
    logic [7:0] tm_sh;
    always @(negedge clk) begin
        if (!reset_ || !mon_en) begin
            tm_busy = 0;
        end else if (!tm_busy) begin
            if (tx === 1'b0) begin
                tm_busy = 1;
                tm_cnt  = BIT_CYC / 2;
                tm_idx  = 0;
            end
        end else begin
            tm_cnt--;
            if (tm_cnt == 0) begin
                if (tm_idx >= 1 && tm_idx <= 8) begin
                    tm_sh = {tx, tm_sh[7:1]};
                end else if (tm_idx == 9) begin
                    tm_busy = 0;
                    cmp("tx_stop_bit", {7'b0, tx}, 8'h01);
                    if (tx_exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL tx_unexpected_byte: got %02h expected none", tm_sh);
                    end else begin
                        cmp("tx_byte", tm_sh, tx_exp_q.pop_front());
                    end
                end
                tm_idx++;
                tm_cnt = BIT_CYC;
            end
        end
    end

    task automatic bus_acc(input bit rnw_i, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] e, input bit chk, input string nm, input int hold);
        bit got;
        exp_q.push_back(e);
        chk_q.push_back(chk);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        bus.cs = 1'b1; bus.req = 1'b1; bus.rnw = rnw_i; bus.addr = a; bus.wr_data = d;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.rdy === 1'b1) got = 1;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: rdy=0 after 20 cycles, required 1", nm);
            void'(exp_q.pop_back());
            void'(chk_q.pop_back());
            void'(name_q.pop_back());
        end
        repeat (hold - 1) @(negedge clk);
        bus.req = 1'b0;
        bus.cs  = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e, input string nm);
        bus_acc(1'b1, a, 8'h00, e, 1'b1, nm, 1);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus_acc(1'b0, a, d, 8'h00, 1'b0, "write", 1);
    endtask

    task automatic host_send(input logic [7:0] b);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (BIT_CYC) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (BIT_CYC) @(posedge clk);
        end
        #1 rx = 1'b1;
        repeat (BIT_CYC) @(posedge clk);
    endtask

    task automatic wait_tx_drain(input int bound);
        for (int i = 0; i < bound && tx_exp_q.size() != 0; i++) @(negedge clk);
        n_cmp++;
        if (tx_exp_q.size() != 0) begin
            n_err++;
            $display("FAIL tx_drain_timeout: %0d bytes still pending, required 0", tx_exp_q.size());
        end
        repeat (40) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        bus.cs = 1'b0; bus.req = 1'b0; bus.rnw = 1'b0; bus.addr = '0; bus.wr_data = '0;
        mon_en = 1;
        repeat (3) @(negedge clk);
        cmp("reset_rd_data", bus.rd_data, 8'h00);
        cmp("reset_rdy", {7'b0, bus.rdy}, 8'h00);
        cmp("reset_irq", {7'b0, bus.irq}, 8'h00);
        cmp("reset_tx", {7'b0, tx}, 8'h01);
        @(posedge clk);
        #1 reset_ = 1'b1;

        for (int a = 0; a < 10; a++) rd(8'(a), (a == 1) ? 8'h45 : 8'h00, "reset_reg");
        rd(8'hFF, 8'h00, "reset_reg_ff");

        // Three back-to-back bytes
        base = txen_cnt;
        tx_exp_q.push_back(8'h41); tx_exp_q.push_back(8'h42); tx_exp_q.push_back(8'h43);
        wr(8'd0, 8'h41); wr(8'd0, 8'h42); wr(8'd0, 8'h43);
        wait_tx_drain(3000);
        cmp("tx_enable_count3", 8'(txen_cnt - base), 8'd3);
        rd(8'd6, 8'h00, "tx_cnt_hi");
        rd(8'd7, 8'h03, "tx_cnt_lo_3");
        rd(8'd1, 8'h45, "status_after_tx");

        // TX overflow while the core is busy with 0x80
        base = txen_cnt;
        tx_exp_q.push_back(8'h80);
        wr(8'd0, 8'h80);
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) tx_exp_q.push_back(8'(8'h90 + i));
            wr(8'd0, 8'(8'h90 + i));
        end
        rd(8'd4, 8'(DEPTH), "tx_level_full");
        rd(8'd1, 8'h20, "status_tx_ovf");
        wr(8'd1, 8'h20);
        rd(8'd1, 8'h00, "status_ovf_cleared");
        wait_tx_drain(8000);
        cmp("tx_enable_count17", 8'(txen_cnt - base), 8'd17);
        rd(8'd7, 8'd20, "tx_cnt_lo_20");
        rd(8'd1, 8'h45, "status_after_burst");

        // RX overflow
        for (int i = 0; i < DEPTH + 2; i++) host_send(8'(8'h30 + i));
        repeat (5) @(negedge clk);
        rd(8'd5, 8'(DEPTH), "rx_level_full");
        rd(8'd1, 8'h5F, "status_rx_ovr");
        rd(8'd8, 8'h00, "rx_cnt_hi");
        rd(8'd9, 8'(DEPTH + 2), "rx_cnt_lo");
        for (int i = 0; i < DEPTH; i++) rd(8'd2, 8'(8'h30 + i), "rx_data_order");
        rd(8'd2, 8'h00, "rx_read_empty");
        wr(8'd1, 8'h10);
        rd(8'd1, 8'h45, "status_ovr_cleared");

        // Interrupt on rx_not_empty
        wr(8'd3, 8'h01);
        host_send(8'h5A);
        for (int i = 0; i < 40 && bus.irq !== 1'b1; i++) @(negedge clk);
        cmp("irq_rx_rise", {7'b0, bus.irq}, 8'h01);
        rd(8'd2, 8'h5A, "rx_data_5a");
        cmp("irq_at_rdy", {7'b0, bus.irq}, 8'h01);
        @(negedge clk);
        cmp("irq_fall", {7'b0, bus.irq}, 8'h00);
        rd(8'd3, 8'h01, "irq_en_rb");
        wr(8'd3, 8'h02);
        repeat (2) @(negedge clk);
        cmp("irq_tx_empty", {7'b0, bus.irq}, 8'h01);
        wr(8'd3, 8'h00);
        repeat (2) @(negedge clk);
        cmp("irq_masked", {7'b0, bus.irq}, 8'h00);

        // Held request: exactly one pop
        host_send(8'h11);
        host_send(8'h22);
        repeat (5) @(negedge clk);
        bus_acc(1'b1, 8'd2, 8'h00, 8'h11, 1'b1, "rx_hold_req", 5);
        rd(8'd5, 8'h01, "rx_level_after_hold");
        rd(8'd2, 8'h22, "rx_data_22");

        // Reset in the middle of TX and RX frames
        host_send(8'h33);
        wr(8'd3, 8'h01);
        repeat (3) @(negedge clk);
        cmp("irq_before_reset", {7'b0, bus.irq}, 8'h01);
        mon_en = 0;
        wr(8'd0, 8'h55); wr(8'd0, 8'h66); wr(8'd0, 8'h77);
        repeat (100) @(posedge clk);
        #1 rx = 1'b0;
        repeat (50) @(posedge clk);
        #1 reset_ = 1'b0;
        @(negedge clk);
        cmp("midrst_rd_data", bus.rd_data, 8'h00);
        cmp("midrst_rdy", {7'b0, bus.rdy}, 8'h00);
        cmp("midrst_irq", {7'b0, bus.irq}, 8'h00);
        cmp("midrst_tx", {7'b0, tx}, 8'h01);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_ = 1'b1;
        mon_en = 1;
        rd(8'd1, 8'h45, "midrst_status");
        rd(8'd4, 8'h00, "midrst_tx_level");
        rd(8'd5, 8'h00, "midrst_rx_level");
        rd(8'd7, 8'h00, "midrst_tx_cnt");
        rd(8'd9, 8'h00, "midrst_rx_cnt");
        rd(8'd3, 8'h00, "midrst_irq_en");
        repeat (400) @(negedge clk);

        cmp("pending_bus_expect", 8'(exp_q.size()), 8'h00);
        cmp("pending_tx_expect", 8'(tx_exp_q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
